// File: rtl/io_bus_arbiter_if.sv
// Bus bundle between the two IO masters, the arbiter and the IO register block.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface io_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_we;
  logic [3:0]        m0_be;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_done;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic              m1_we;
  logic [3:0]        m1_be;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_done;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] io_addr;
  logic              io_we;
  logic [3:0]        io_be;
  logic [DATA_W-1:0] io_wdata;
  logic [DATA_W-1:0] io_rdata;

  logic              busy;

  modport slave (
    input  m0_req, m0_addr, m0_we, m0_be, m0_wdata,
    output m0_gnt, m0_done, m0_rdata,
    input  m1_req, m1_addr, m1_we, m1_be, m1_wdata,
    output m1_gnt, m1_done, m1_rdata,
    output io_addr, io_we, io_be, io_wdata,
    input  io_rdata,
    output busy
  );

  modport master (
    output m0_req, m0_addr, m0_we, m0_be, m0_wdata,
    input  m0_gnt, m0_done, m0_rdata,
    output m1_req, m1_addr, m1_we, m1_be, m1_wdata,
    input  m1_gnt, m1_done, m1_rdata,
    input  io_addr, io_we, io_be, io_wdata,
    output io_rdata,
    input  busy
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// Two-master arbiter/sequencer for the IO register block: grant, one-cycle issue, response.
// Define IO_ARB_FIXED_PRIO_EN for fixed priority (m0 wins ties); default is round-robin.
//
// state | meaning
// IDLE  | waiting for a request; grant and capture payload on the same edge
// ISSUE | captured request driven onto the IO port for one cycle
// RESP  | done pulse (and read data) to the owner; pointer update
module io_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  io_bus_arbiter_if.slave bus
);

  if (DATA_W != 32) begin : g_bad_width
    $error("io_bus_arbiter: DATA_W must be 32");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;

  logic              owner;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [3:0]        cap_be;
  logic [DATA_W-1:0] cap_wdata;

  logic              any_req;
  logic              pick_m1;
  logic              accept;

  assign any_req = bus.m0_req | bus.m1_req;
  assign accept  = (state == IDLE) & any_req;

`ifdef IO_ARB_FIXED_PRIO_EN
  // m1 only wins when m0 is silent; it can starve under continuous m0 traffic.
  assign pick_m1 = bus.m1_req & ~bus.m0_req;
`else
  logic last_owner;

  // On a tie the master that was not served last wins.
  assign pick_m1 = bus.m1_req & (~bus.m0_req | ~last_owner);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner <= 1'b1;
    end else if (state == RESP) begin
      last_owner <= owner;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ISSUE;
      ISSUE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_be    <= '0;
      cap_wdata <= '0;
    end else if (accept) begin
      owner <= pick_m1;
      if (pick_m1) begin
        cap_we    <= bus.m1_we;
        cap_addr  <= bus.m1_addr;
        cap_be    <= bus.m1_be;
        cap_wdata <= bus.m1_wdata;
      end else begin
        cap_we    <= bus.m0_we;
        cap_addr  <= bus.m0_addr;
        cap_be    <= bus.m0_be;
        cap_wdata <= bus.m0_wdata;
      end
    end
  end

  // Grants are gated by reset so no master sees an accept while the block is held.
  always_comb begin
    bus.m0_gnt   = 1'b0;
    bus.m1_gnt   = 1'b0;
    bus.m0_done  = 1'b0;
    bus.m1_done  = 1'b0;
    bus.m0_rdata = '0;
    bus.m1_rdata = '0;
    bus.io_addr  = '0;
    bus.io_we    = 1'b0;
    bus.io_be    = '0;
    bus.io_wdata = '0;
    bus.busy     = 1'b0;
    case (state)
      IDLE: begin
        bus.m0_gnt = accept & ~pick_m1 & ~reset;
        bus.m1_gnt = accept &  pick_m1 & ~reset;
      end
      ISSUE: begin
        bus.busy     = 1'b1;
        bus.io_addr  = cap_addr;
        bus.io_we    = cap_we;
        bus.io_be    = cap_be;
        bus.io_wdata = cap_wdata;
      end
      RESP: begin
        bus.busy = 1'b1;
        if (owner) begin
          bus.m1_done  = 1'b1;
          bus.m1_rdata = cap_we ? '0 : bus.io_rdata;
        end else begin
          bus.m0_done  = 1'b1;
          bus.m0_rdata = cap_we ? '0 : bus.io_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter with a small LED/switch/button register model.
module tb_io_bus_arbiter;

  localparam logic [31:0] SW_VAL  = 32'h0000_00C3;
  localparam logic [31:0] BTN_VAL = 32'h0000_0005;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_bad;

  io_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  io_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] led_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q        <= '0;
      bus.io_rdata <= '0;
    end else begin
      if (bus.io_we && bus.io_addr == 32'h0) begin
        for (int i = 0; i < 4; i++) begin
          if (bus.io_be[i]) led_q[8*i +: 8] <= bus.io_wdata[8*i +: 8];
        end
      end
      case (bus.io_addr)
        32'h0:   bus.io_rdata <= led_q;
        32'h4:   bus.io_rdata <= SW_VAL;
        32'h8:   bus.io_rdata <= BTN_VAL;
        default: bus.io_rdata <= '0;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_reqs();
    bus.m0_req = 0; bus.m0_addr = 0; bus.m0_we = 0; bus.m0_be = 0; bus.m0_wdata = 0;
    bus.m1_req = 0; bus.m1_addr = 0; bus.m1_we = 0; bus.m1_be = 0; bus.m1_wdata = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_reqs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_req(input bit m, input logic [31:0] addr, input bit we,
                         input logic [3:0] be, input logic [31:0] wdata);
    if (m) begin
      bus.m1_req = 1; bus.m1_addr = addr; bus.m1_we = we; bus.m1_be = be; bus.m1_wdata = wdata;
    end else begin
      bus.m0_req = 1; bus.m0_addr = addr; bus.m0_we = we; bus.m0_be = be; bus.m0_wdata = wdata;
    end
  endtask

  // Full single-master transaction starting from IDLE, checked cycle by cycle.
  task automatic txn(input bit m, input logic [31:0] addr, input bit we,
                     input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] exp_rd);
    @(negedge clk);
    set_req(m, addr, we, be, wdata);
    #1;
    chk("gnt_own",   m ? bus.m1_gnt : bus.m0_gnt, 1);
    chk("gnt_other", m ? bus.m0_gnt : bus.m1_gnt, 0);
    @(posedge clk); #1;
    clear_reqs();
    chk("issue_we",    {31'd0, bus.io_we}, {31'd0, we});
    chk("issue_addr",  bus.io_addr, addr);
    chk("issue_be",    {28'd0, bus.io_be}, {28'd0, be});
    chk("issue_wdata", bus.io_wdata, wdata);
    chk("issue_flags", {bus.busy, bus.m0_done, bus.m1_done, bus.m0_gnt, bus.m1_gnt}, 32'h10);
    @(posedge clk); #1;
    chk("resp_done_own",   m ? bus.m1_done : bus.m0_done, 1);
    chk("resp_done_other", m ? bus.m0_done : bus.m1_done, 0);
    chk("resp_rdata_own",  m ? bus.m1_rdata : bus.m0_rdata, we ? 32'h0 : exp_rd);
    chk("resp_rdata_other", m ? bus.m0_rdata : bus.m1_rdata, 0);
    chk("resp_io_we_busy", {bus.io_we, bus.busy}, 2'b01);
    @(posedge clk); #1;
    chk("idle_busy", bus.busy, 0);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    reset = 1'b1;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done, bus.busy, bus.io_we}, 0);
    chk("rst_io", bus.io_addr | bus.io_wdata | {28'd0, bus.io_be}, 0);
    chk("rst_rdata", bus.m0_rdata | bus.m1_rdata, 0);
    @(negedge clk);
    reset = 1'b0;

    // Idle bus
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_io", bus.io_addr | bus.io_wdata | {26'd0, bus.io_be, bus.io_we, bus.busy}, 0);
    end

    // Single write then read-back by the other master
    txn(0, 32'h0, 1, 4'hF, 32'hA5A5_5A5A, 32'h0);
    txn(1, 32'h0, 0, 4'hF, 32'h0, 32'hA5A5_5A5A);

    // Byte-lane write
    txn(0, 32'h0, 1, 4'hF, 32'h0, 32'h0);
    txn(1, 32'h0, 1, 4'b0010, 32'hFFFF_3CFF, 32'h0);
    txn(1, 32'h0, 0, 4'hF, 32'h0, 32'h0000_3C00);

    // Switches, buttons, undecoded offset, write to read-only offset
    txn(0, 32'h4, 0, 4'hF, 32'h0, SW_VAL);
    txn(1, 32'h8, 0, 4'hF, 32'h0, BTN_VAL);
    txn(0, 32'hC, 0, 4'hF, 32'h0, 32'h0);
    txn(0, 32'h4, 1, 4'hF, 32'h1111_1111, 32'h0);
    txn(0, 32'h0, 0, 4'hF, 32'h0, 32'h0000_3C00);

    // Tie from reset
    reset = 1'b1;
    clear_reqs();
    set_req(0, 32'h4, 0, 4'hF, 32'h0);
    set_req(1, 32'h8, 0, 4'hF, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("tie_gnt_in_reset", {bus.m0_gnt, bus.m1_gnt}, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      bit w1;
`ifdef IO_ARB_FIXED_PRIO_EN
      w1 = 1'b0;
`else
      w1 = (k % 2) == 1;
`endif
      chk("tie_gnt", {bus.m0_gnt, bus.m1_gnt}, w1 ? 2'b01 : 2'b10);
      @(posedge clk); #1;
      chk("tie_issue_nognt", {bus.m0_gnt, bus.m1_gnt}, 0);
      chk("tie_issue_addr", bus.io_addr, w1 ? 32'h8 : 32'h4);
      @(posedge clk); #1;
      chk("tie_resp_nognt", {bus.m0_gnt, bus.m1_gnt}, 0);
      chk("tie_done", {bus.m0_done, bus.m1_done}, w1 ? 2'b01 : 2'b10);
      chk("tie_rdata", w1 ? bus.m1_rdata : bus.m0_rdata, w1 ? BTN_VAL : SW_VAL);
      @(posedge clk); #1;
    end
    clear_reqs();

    // Late arrival of m1 during m0's ISSUE
    do_reset();
    set_req(0, 32'h0, 1, 4'hF, 32'h0000_00FF);
    #1;
    chk("late_m0_gnt", {bus.m0_gnt, bus.m1_gnt}, 2'b10);
    @(posedge clk); #1;
    bus.m0_req = 0;
    set_req(1, 32'h0, 0, 4'hF, 32'h0);
    #1;
    chk("late_issue_nognt", {bus.m0_gnt, bus.m1_gnt}, 0);
    @(posedge clk); #1;
    chk("late_resp", {bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done}, 4'b0010);
    @(posedge clk); #1;
    chk("late_m1_gnt", {bus.m0_gnt, bus.m1_gnt}, 2'b01);
    @(posedge clk); #1;
    clear_reqs();
    @(posedge clk); #1;
    chk("late_m1_done", {bus.m0_done, bus.m1_done}, 2'b01);
    chk("late_m1_rdata", bus.m1_rdata, 32'h0000_00FF);
    @(posedge clk); #1;

    // Reset asserted mid-ISSUE
    @(negedge clk);
    set_req(0, 32'h0, 1, 4'hF, 32'h0000_1234);
    @(posedge clk); #1;
    clear_reqs();
    chk("midrst_pre_we", bus.io_we, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_io_we", bus.io_we, 0);
    chk("midrst_flags", {bus.busy, bus.m0_done, bus.m1_done, bus.m0_gnt, bus.m1_gnt}, 0);
    chk("midrst_io", bus.io_addr | bus.io_wdata | {28'd0, bus.io_be}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_nodone", {bus.m0_done, bus.m1_done, bus.busy}, 0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("postrst_idle", {bus.busy, bus.m0_done, bus.io_we}, 0);
    txn(1, 32'h0, 0, 4'hF, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
